// File: rtl/seq_scan_ctrl.sv
// Frame controller: serialises a parallel word MSB-first, scans it for a programmable
// pattern, drives the downstream detector's clear/strobe and reports the match count.
module seq_scan_ctrl #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              det_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_hit,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CLEAR  = 2'b01,
    SHIFT  = 2'b10,
    REPORT = 2'b11
  } state_t;

  state_t            st;
  logic [DATA_W-1:0] shreg;
  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  win_next;
  logic [FW-1:0]     fill;
  logic [FW-1:0]     fill_next;
  logic [BW-1:0]     bitcnt;
  logic [CNT_W-1:0]  count;
  logic              overlap;
  logic              match;

  // Window/fill as they will be after the current serial bit is absorbed.
  always_comb begin
    win_next  = {window[PAT_W-2:0], shreg[DATA_W-1]};
    fill_next = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    match     = (fill_next == FW'(PAT_W)) && (win_next == pattern);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      shreg   <= '0;
      window  <= '0;
      fill    <= '0;
      bitcnt  <= '0;
      count   <= '0;
      pattern <= '0;
      overlap <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (cfg_we) begin
            pattern <= cfg_pattern;
            overlap <= cfg_overlap;
          end
          if (in_valid) begin
            shreg <= in_data;
            st    <= CLEAR;
          end
        end
        CLEAR: begin
          window <= '0;
          fill   <= '0;
          bitcnt <= '0;
          count  <= '0;
          st     <= SHIFT;
        end
        SHIFT: begin
          shreg  <= {shreg[DATA_W-2:0], 1'b0};
          window <= win_next;
          bitcnt <= bitcnt + 1'b1;
          // Non-overlapping mode forces PAT_W fresh bits before the next match.
          fill   <= (match && !overlap) ? '0 : fill_next;
          if (match && (count != '1))
            count <= count + 1'b1;
          if (bitcnt == BW'(DATA_W - 1))
            st <= REPORT;
        end
        REPORT: begin
          if (out_ready)
            st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state     = st;
  assign in_ready  = rst && (st == IDLE);
  assign busy      = (st != IDLE);
  assign det_clr   = (st == CLEAR);
  assign ser_valid = (st == SHIFT);
  assign ser_bit   = ser_valid & shreg[DATA_W-1];
  assign out_valid = (st == REPORT);
  assign out_count = count;
  assign out_hit   = |count;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a CNT_W=5 and a CNT_W=3 instance share stimulus;
// expected results are queued at frame acceptance and compared when the result appears.
module tb_seq_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_pattern = '0;
  logic        cfg_overlap = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, ser_bit, ser_valid, det_clr, out_valid, out_hit, busy;
  logic [4:0]  out_count;
  logic [1:0]  state;
  logic        in_ready2, ser_bit2, ser_valid2, det_clr2, out_valid2, out_hit2, busy2;
  logic [2:0]  out_count2;
  logic [1:0]  state2;

  int total = 0;
  int bad = 0;
  logic [4:0] exp_q[$];
  logic [2:0] exp2_q[$];

  seq_scan_ctrl #(.DATA_W(16), .PAT_W(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .ser_bit(ser_bit),
    .ser_valid(ser_valid), .det_clr(det_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_hit(out_hit), .busy(busy), .state(state)
  );

  seq_scan_ctrl #(.DATA_W(16), .PAT_W(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .ser_bit(ser_bit2),
    .ser_valid(ser_valid2), .det_clr(det_clr2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_count(out_count2), .out_hit(out_hit2), .busy(busy2), .state(state2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [3:0] pat, input logic ov);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ov;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Drives one frame, checks the cycle-exact sequencing and the reported count.
  // hold: cycles of out_ready=0 in REPORT (with a competing in_valid); mid_cfg: write 0000 during SHIFT.
  task automatic run_frame(input string tag, input logic [15:0] d, input logic [4:0] e,
                           input int hold, input bit mid_cfg);
    int nser;
    logic [4:0] held;
    logic [4:0] ev;
    logic [2:0] ev2;
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    exp_q.push_back(e);
    exp2_q.push_back((e > 5'd7) ? 3'd7 : e[2:0]);
    @(negedge clk);
    check({tag, ".det_clr"}, det_clr, 1);
    check({tag, ".clr_state"}, state, 2'b01);
    nser = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ser_valid) nser++;
      check({tag, ".ser_bit"}, ser_bit, d[15-i]);
      if (mid_cfg && i == 3) begin
        cfg_we = 1'b1; cfg_pattern = 4'b0000;
      end else begin
        cfg_we = 1'b0;
      end
    end
    check({tag, ".ser_cycles"}, nser, 16);
    @(negedge clk);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".ser_idle"}, ser_bit, 0);
    held = out_count;
    if (hold > 0) begin
      in_valid = 1'b1; in_data = 16'hFFFF;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, out_valid, 1);
        check({tag, ".hold_count"}, out_count, held);
        check({tag, ".hold_in_ready"}, in_ready, 0);
      end
    end
    check({tag, ".q_nonempty"}, exp_q.size(), 1);
    ev = exp_q.pop_front();
    ev2 = exp2_q.pop_front();
    check({tag, ".count"}, out_count, ev);
    check({tag, ".hit"}, out_hit, (ev != 0));
    check({tag, ".count_sat"}, out_count2, ev2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".done_valid"}, out_valid, 0);
    check({tag, ".done_state"}, state, 2'b00);
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    check("rst.state", state, 2'b00);
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.ser_valid", ser_valid, 0);
    check("rst.det_clr", det_clr, 0);
    check("rst.busy", busy, 0);
    check("rst.count", out_count, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    configure(4'b1011, 1'b1);
    run_frame("b000", 16'hB000, 5'd1, 0, 1'b0);
    configure(4'b1111, 1'b1);
    run_frame("ffff_ov", 16'hFFFF, 5'd13, 0, 1'b0);
    configure(4'b1111, 1'b0);
    run_frame("ffff_nov", 16'hFFFF, 5'd4, 0, 1'b0);
    configure(4'b1011, 1'b1);
    run_frame("zero", 16'h0000, 5'd0, 0, 1'b0);
    run_frame("backpressure", 16'hB000, 5'd1, 5, 1'b0);
    run_frame("cfg_in_shift", 16'hB000, 5'd1, 0, 1'b1);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b1;
    run_frame("cfg_same_cycle", 16'hF000, 5'd1, 0, 1'b0);

    // Abort a frame with reset in its 8th SHIFT cycle.
    @(negedge clk);
    in_data = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.pre_state", state, 2'b10);
    rst = 1'b0;
    #1;
    check("abort.state", state, 2'b00);
    check("abort.ser_valid", ser_valid, 0);
    check("abort.ser_bit", ser_bit, 0);
    check("abort.in_ready", in_ready, 0);
    check("abort.busy", busy, 0);
    check("abort.count", out_count, 0);
    check("abort.out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    configure(4'b1011, 1'b1);
    run_frame("after_abort", 16'hB000, 5'd1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
